pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV pipeline that owns the IF/ID and ID/EX pipeline registers.
- Detects load-use data hazards, taken-branch redirects, and structural hazards on the multi-cycle matrix unit fed by the 128-bit ID/EX matrix operand.
- Drives pc_stall, if_id_stall, if_id_flush and id_ex_flush so the ID/EX register receives a clean bubble whenever ID must not advance.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/mat_occupancy_tracker.sv | 64 ++++++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Provides the matrix-unit occupancy state type, the register index width,
// the default matrix latency, and the x0 register index.
package pipe_pkg;

  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned MAT_LAT_DEFAULT = 4;

  // x0 is hardwired to zero, so a write to it can never create a RAW hazard.
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mat_state_e;

endpackage

// File: rtl/mat_occupancy_tracker.sv
// Matrix-unit occupancy tracker.
// Tracks whether the multi-cycle matrix unit is occupied. An issue reloads
// the countdown with MAT_LAT-1. The unit is released once the count reaches 0.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   issue        a matrix op advances from ID into EX on this edge
//   id_is_matrix instruction in ID is a matrix op
//   mat_busy     unit occupied (forced low during reset)
//   struct_hz    structural hazard: matrix op in ID while unit still counting
module mat_occupancy_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MAT_LAT = MAT_LAT_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic id_is_matrix,
  output logic mat_busy,
  output logic struct_hz
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MAT_LAT - 1);

  mat_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A reload at cnt==0 keeps BUSY, giving back-to-back ops
  // spaced exactly MAT_LAT cycles apart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (issue) begin
      state_d = BUSY;
      cnt_d   = CNT_RELOAD;
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    mat_busy  = rst & (state_q == BUSY);
    struct_hz = id_is_matrix & mat_busy & (cnt_q != '0);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (owns IF/ID and ID/EX).
// Detects load-use hazards, taken-branch redirects, and structural hazards
// on the multi-cycle matrix unit. All control outputs are combinational.
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   id_rs1/id_rs2 (+_used)     source registers of the instruction in ID
//   id_is_matrix               instruction in ID is a matrix op
//   ex_rd, ex_mem_read         destination/load flag of the instruction in EX
//   ex_br_taken                branch/jump in EX resolved taken
//   pc_stall, if_id_stall      hold PC / IF/ID register
//   if_id_flush, id_ex_flush   clear IF/ID / load a bubble into ID/EX
//   mat_busy                   matrix unit occupied
// Optional (macro HAZ_PERF_CNT_EN):
//   perf_stall_cnt             cycles with pc_stall=1 (wraps at 2^32)
//   perf_flush_cnt             out-of-reset cycles with if_id_flush=1
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MAT_LAT = MAT_LAT_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       id_is_matrix,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_br_taken,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mat_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic load_use;
  logic struct_hz;
  logic redirect;
  logic issue;

  always_comb begin
    load_use = ex_mem_read & (ex_rd != REG_X0) &
               ((id_rs1_used & (id_rs1 == ex_rd)) |
                (id_rs2_used & (id_rs2 == ex_rd)));
    redirect = ex_br_taken;
  end

  // Redirect wins over stalls: the ID instruction is killed anyway.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use | struct_hz) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // A matrix op only issues when ID actually advances into EX.
  always_comb begin
    issue = id_is_matrix & ~id_ex_flush & rst;
  end

  mat_occupancy_tracker #(
    .MAT_LAT (MAT_LAT),
    .CNT_W   (CNT_W)
  ) u_mat_occ (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .id_is_matrix (id_is_matrix),
    .mat_busy     (mat_busy),
    .struct_hz    (struct_hz)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall)    perf_stall_q <= perf_stall_q + 32'd1;
      if (if_id_flush) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MAT_LAT=4 and MAT_LAT=1 instances).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, id_is_matrix, ex_mem_read, ex_br_taken;

  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, mat_busy;
  logic d1_pc_stall, d1_if_id_stall, d1_if_id_flush, d1_id_ex_flush, d1_mat_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [31:0] d1_perf_stall_cnt, d1_perf_flush_cnt;
`endif

  logic [3:0] ctl, d1_ctl;
  assign ctl    = {pc_stall, if_id_stall, if_id_flush, id_ex_flush};
  assign d1_ctl = {d1_pc_stall, d1_if_id_stall, d1_if_id_flush, d1_id_ex_flush};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAT_LAT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_is_matrix (id_is_matrix),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_br_taken  (ex_br_taken),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mat_busy     (mat_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  pipe_hazard_ctrl #(.MAT_LAT(1), .CNT_W(8)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_is_matrix (id_is_matrix),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_br_taken  (ex_br_taken),
    .pc_stall     (d1_pc_stall),
    .if_id_stall  (d1_if_id_stall),
    .if_id_flush  (d1_if_id_flush),
    .id_ex_flush  (d1_id_ex_flush),
    .mat_busy     (d1_mat_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (d1_perf_stall_cnt),
    .perf_flush_cnt (d1_perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
  task automatic check_ctl(input string tag, input logic [3:0] got, input logic [3:0] exp);
    check(tag, {28'd0, got}, {28'd0, exp});
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    check(tag, {31'd0, got}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1       = '0;
    id_rs2       = '0;
    ex_rd        = '0;
    id_rs1_used  = 1'b0;
    id_rs2_used  = 1'b0;
    id_is_matrix = 1'b0;
    ex_mem_read  = 1'b0;
    ex_br_taken  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    id_is_matrix = 1'b1;
    tick();
    tick();
    #1;
    check_ctl("rst_ctl", ctl, 4'b0011);
    check_bit("rst_busy", mat_busy, 1'b0);

    // Out of reset, idle
    rst = 1'b1;
    id_is_matrix = 1'b0;
    #1;
    check_ctl("idle_ctl", ctl, 4'b0000);

    // Load-use hazards (combinational)
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1; check_ctl("lu_rs1", ctl, 4'b1101);
    ex_rd = 5'd0;
    #1; check_ctl("lu_rd_zero", ctl, 4'b0000);
    id_rs1 = 5'd0;
    #1; check_ctl("lu_x0_match", ctl, 4'b0000);
    id_rs1 = 5'd5; ex_rd = 5'd5; id_rs1_used = 1'b0;
    #1; check_ctl("lu_rs1_unused", ctl, 4'b0000);
    id_rs2 = 5'd5; id_rs2_used = 1'b1;
    tick(); check_ctl("lu_rs2", ctl, 4'b1101);
    ex_mem_read = 1'b0;
    #1; check_ctl("lu_not_load", ctl, 4'b0000);
    ex_mem_read = 1'b1; ex_br_taken = 1'b1;
    #1; check_ctl("redir_over_lu", ctl, 4'b0011);
    idle_inputs(); ex_br_taken = 1'b1;
    #1; check_ctl("redir_only", ctl, 4'b0011);
    idle_inputs();
    tick();

    // Structural hazard, MAT_LAT=4
    id_is_matrix = 1'b1;
    #1;
    check_ctl("mat_first_issue", ctl, 4'b0000);
    check_bit("mat_busy_pre", mat_busy, 1'b0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      check_ctl("struct_stall", ctl, 4'b1101);
      check_bit("struct_busy", mat_busy, 1'b1);
      tick();
    end
    check_ctl("struct_release", ctl, 4'b0000);
    check_bit("struct_busy_release", mat_busy, 1'b1);
    tick();

    // Taken branch does not cancel the occupying op
    ex_br_taken = 1'b1;
    #1;
    check_ctl("redir_over_struct", ctl, 4'b0011);
    check_bit("redir_busy", mat_busy, 1'b1);
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      check_bit("countdown_busy", mat_busy, 1'b1);
      tick();
    end
    check_bit("countdown_done", mat_busy, 1'b0);

    // Reset while BUSY
    id_is_matrix = 1'b1;
    tick();
    id_is_matrix = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_ctl("rst_mid_ctl", ctl, 4'b0011);
    check_bit("rst_mid_busy", mat_busy, 1'b0);
    tick();
    rst = 1'b1;
    id_is_matrix = 1'b1;
    #1;
    check_bit("rst_after_busy", mat_busy, 1'b0);
    check_ctl("rst_after_ctl", ctl, 4'b0000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle_inputs();

    // MAT_LAT=1: back-to-back matrix ops never stall
    id_is_matrix = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctl("lat1_no_stall", d1_ctl, 4'b0000);
      check_bit("lat1_busy", d1_mat_busy, (i != 0));
      tick();
    end
    id_is_matrix = 1'b0;
    check_bit("lat1_busy_last", d1_mat_busy, 1'b1);
    tick();
    check_bit("lat1_idle", d1_mat_busy, 1'b0);

`ifdef HAZ_PERF_CNT_EN
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    tick(); tick(); tick();
    idle_inputs();
    ex_br_taken = 1'b1;
    tick(); tick();
    idle_inputs();
    #1;
    check("perf_stall", perf_stall_cnt, 32'd3);
    check("perf_flush", perf_flush_cnt, 32'd2);
    force dut.perf_stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall_q;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    tick();
    idle_inputs();
    check("perf_stall_wrap", perf_stall_cnt, 32'd0);
    check("perf_flush_hold", perf_flush_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
